comparator_serial_n_bit: RTL and testbench
==========================================

// Module: comparator_serial_n_bit
// PURPOSE
// - Parametrised, multi-cycle magnitude comparator; successor to the combinational 4-bit comparator.
// - Compares two WIDTH-bit operands DIGIT_W bits per clock, MSB digit first, with early termination.
// - Start/Busy/Done handshake. Sits in datapaths where wide operands must not create a long compare path.
// PARAMETERS
// - WIDTH     16  operand width in bits; must be an integer multiple of DIGIT_W
// - DIGIT_W    4  bits compared per clock; NUM_DIGITS = WIDTH/DIGIT_W (>=1)
// PORTS
// - Clk_In      in   1            clock, rising edge
// - Reset_n_In  in   1            asynchronous, active-low reset
// - Enable_In   in   1            block enable; low aborts any operation, holds block idle
// - Start_In    in   1            start request; sampled only in IDLE with Enable_In=1
// - Data_A_In   in   WIDTH        operand A, captured on accepted Start_In
// - Data_B_In   in   WIDTH        operand B, captured on accepted Start_In
// - Signed_In   in   1            two's-complement compare mode (present only with COMPARATOR_SIGNED_EN)
// - Busy_Out    out  1            operation in progress
// - Done_Out    out  1            one-cycle pulse: result valid, updated this cycle
// - A_gt_B_Out  out  1            A > B, held until next accepted start/abort
// - A_eq_B_Out  out  1            A == B, held
// - A_lt_B_Out  out  1            A < B, held
// - Cycles_Out  out  clog2(NUM_DIGITS+1)  digits examined for last result
// BEHAVIOUR
// - Reset (async, Reset_n_In=0): state IDLE; all outputs 0; operand registers 0.
// - FSM: IDLE -> BUSY on Enable_In & Start_In; BUSY -> IDLE on resolve or abort. No DONE state.
// - Start accepted at edge T: A/B latched, digit index=0 (MSB), Busy_Out=1, result outputs cleared to 0.
// - Digit i compared at edge T+1+i. If digits differ: set gt/lt, eq=0, Done_Out=1, Cycles_Out=i+1, Busy=0.
// - If all NUM_DIGITS digits equal: at edge T+NUM_DIGITS set eq=1, Done_Out=1, Cycles_Out=NUM_DIGITS.
// - Latency start->Done_Out visible: 1..NUM_DIGITS cycles. Exactly one of gt/eq/lt =1 while Done_Out=1.
// - Done_Out high exactly one cycle; results/Cycles_Out hold until next accepted start or abort.
// - Start_In while BUSY ignored (no restart, no queueing). Start_In with Enable_In=0 ignored.
// - Back-to-back: Start_In in Done_Out cycle is accepted (state already IDLE).
// - Enable_In=0 at any edge: state IDLE, Busy=0, Done=0, gt/eq/lt=0, Cycles_Out=0; no Done for aborted op.
// - Reset mid-operation: immediate return to reset values; no Done_Out.
// - Data_A_In/Data_B_In changes after acceptance have no effect on the running compare.
// - NUM_DIGITS=1: pure one-cycle registered comparator, Cycles_Out always 1.
// CONFIGURATION
// - Macro COMPARATOR_SIGNED_EN defined: Signed_In port exists, sampled with Start_In. When 1, sign bit
//   (bit WIDTH-1) of both operands inverted before MSB-digit compare -> two's-complement ordering.
// - Macro undefined: Signed_In port absent; unsigned compare only; no sign-inversion logic.
// TESTING (WIDTH=16, DIGIT_W=4 unless noted)
// - A=0x9234,B=0x1234 start -> Done after 1 cycle, gt=1, Cycles_Out=1, Busy high 1 cycle.
// - A=0x1234,B=0x1235 -> Done after 4 cycles, lt=1, Cycles_Out=4; A=B=0xFFFF -> eq=1, Cycles_Out=4.
// - SIGNED_EN: A=0x8000,B=0x0001, Signed_In=1 -> lt=1; Signed_In=0 -> gt=1 (both Cycles_Out=1).
// - Start at edge T with A=0x1230,B=0x1231, second Start at T+2 with other data -> ignored, one Done, lt=1.
// - Enable_In dropped at T+2 of a 4-digit equal compare -> no Done, all outputs 0; Reset_n_In pulse same.
// - 200 random ops, random Enable_In/Start_In/Signed_In -> outputs match reference model every Done.

Source files
------------

// File: rtl/comparator_serial_n_bit.sv
// Purpose: serial magnitude comparator. Compares two WIDTH-bit operands DIGIT_W bits per clock,
//          MSB digit first, and stops at the first digit that differs.
// Latency: Done_Out rises 1..NUM_DIGITS cycles after the accepting edge (one cycle per digit examined).
// Backpressure: none. Start_In is sampled only while idle and enabled; a start while busy is dropped.
//
// Ports:
//   Clk_In, Reset_n_In            clock (rising edge), asynchronous active-low reset
//   Enable_In                     low aborts any operation and clears every output
//   Start_In, Data_A_In/Data_B_In start request and operands, captured together on acceptance
//   Signed_In                     two's-complement mode; exists only when COMPARATOR_SIGNED_EN is defined
//   Busy_Out, Done_Out            operation in progress / one-cycle result-valid pulse
//   A_gt_B_Out/A_eq_B_Out/A_lt_B_Out  result flags, held until the next accepted start or abort
//   Cycles_Out                    number of digits examined to reach the held result
// Optional feature macro: COMPARATOR_SIGNED_EN (signed compare mode).

module comparator_serial_n_bit #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic                                  Clk_In,
    input  logic                                  Reset_n_In,
    input  logic                                  Enable_In,
    input  logic                                  Start_In,
    input  logic [WIDTH-1:0]                      Data_A_In,
    input  logic [WIDTH-1:0]                      Data_B_In,
`ifdef COMPARATOR_SIGNED_EN
    input  logic                                  Signed_In,
`endif
    output logic                                  Busy_Out,
    output logic                                  Done_Out,
    output logic                                  A_gt_B_Out,
    output logic                                  A_eq_B_Out,
    output logic                                  A_lt_B_Out,
    output logic [$clog2(WIDTH/DIGIT_W+1)-1:0]    Cycles_Out
);

    localparam int NUM_DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(NUM_DIGITS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Operands are shifted left one digit per cycle so the digit under test
    // is always the top DIGIT_W bits; no wide index mux is needed.
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cyc_q;
    logic             done_q, gt_q, eq_q, lt_q;

    logic [WIDTH-1:0] a_load, b_load;
    logic [DIGIT_W-1:0] dig_a, dig_b;
    logic             dig_ne, dig_gt, last_dig, accept, resolve;

`ifdef COMPARATOR_SIGNED_EN
    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the digit datapath stays unsigned.
    logic [WIDTH-1:0] sign_mask;
    assign sign_mask = Signed_In ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    assign a_load    = Data_A_In ^ sign_mask;
    assign b_load    = Data_B_In ^ sign_mask;
`else
    assign a_load    = Data_A_In;
    assign b_load    = Data_B_In;
`endif

    assign dig_a    = a_q[WIDTH-1 -: DIGIT_W];
    assign dig_b    = b_q[WIDTH-1 -: DIGIT_W];
    assign dig_ne   = (dig_a != dig_b);
    assign dig_gt   = (dig_a > dig_b);
    assign last_dig = (idx_q == LAST_IDX);
    assign accept   = (state_q == IDLE) && Enable_In && Start_In;
    assign resolve  = (state_q == BUSY) && (dig_ne || last_dig);

    // State register
    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; disable wins over everything
    always_comb begin
        state_d = state_q;
        if (!Enable_In) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (Start_In) state_d = BUSY;
                BUSY:    if (resolve)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and result registers
    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            a_q    <= '0;
            b_q    <= '0;
            idx_q  <= '0;
            cyc_q  <= '0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!Enable_In) begin
                a_q   <= '0;
                b_q   <= '0;
                idx_q <= '0;
                cyc_q <= '0;
                gt_q  <= 1'b0;
                eq_q  <= 1'b0;
                lt_q  <= 1'b0;
            end else if (accept) begin
                a_q   <= a_load;
                b_q   <= b_load;
                idx_q <= '0;
                cyc_q <= '0;
                gt_q  <= 1'b0;
                eq_q  <= 1'b0;
                lt_q  <= 1'b0;
            end else if (state_q == BUSY) begin
                if (dig_ne) begin
                    gt_q   <= dig_gt;
                    lt_q   <= ~dig_gt;
                    done_q <= 1'b1;
                    cyc_q  <= idx_q + CNT_W'(1);
                end else if (last_dig) begin
                    eq_q   <= 1'b1;
                    done_q <= 1'b1;
                    cyc_q  <= ALL_CNT;
                end else begin
                    a_q   <= a_q << DIGIT_W;
                    b_q   <= b_q << DIGIT_W;
                    idx_q <= idx_q + CNT_W'(1);
                end
            end
        end
    end

    assign Busy_Out   = (state_q == BUSY);
    assign Done_Out   = done_q;
    assign A_gt_B_Out = gt_q;
    assign A_eq_B_Out = eq_q;
    assign A_lt_B_Out = lt_q;
    assign Cycles_Out = cyc_q;

endmodule

// File: tb/tb_comparator_serial_n_bit.sv
module tb_comparator_serial_n_bit;

    localparam int WIDTH   = 16;
    localparam int DIGIT_W = 4;
    localparam int ND      = WIDTH / DIGIT_W;
    localparam int CW      = $clog2(ND + 1);

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              start;
    logic [WIDTH-1:0]  data_a;
    logic [WIDTH-1:0]  data_b;
    logic              sgn;
    logic              busy;
    logic              done;
    logic              gt, eq, lt;
    logic [CW-1:0]     cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    comparator_serial_n_bit #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .Clk_In     (clk),
        .Reset_n_In (rst_n),
        .Enable_In  (enable),
        .Start_In   (start),
        .Data_A_In  (data_a),
        .Data_B_In  (data_b),
`ifdef COMPARATOR_SIGNED_EN
        .Signed_In  (sgn),
`endif
        .Busy_Out   (busy),
        .Done_Out   (done),
        .A_gt_B_Out (gt),
        .A_eq_B_Out (eq),
        .A_lt_B_Out (lt),
        .Cycles_Out (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       res;   // {gt, eq, lt}
        int               cyc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until Done_Out is seen, bounded; lat counts edges stepped.
    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < ND + 3) begin
            step();
            lat++;
            if (done) got = 1'b1;
        end
    endtask

    // Reference: ordering from plain arithmetic, digit count from the
    // position of the most significant differing bit.
    function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s, output logic [2:0] res, output int cyc);
        logic [WIDTH-1:0] diff;
        int msb;
        diff = a ^ b;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if (diff[i]) msb = i;
        cyc = (msb < 0) ? ND : ND - (msb / DIGIT_W);
        if (s) res = {($signed(a) > $signed(b)), (a == b), ($signed(a) < $signed(b))};
        else   res = {(a > b), (a == b), (a < b)};
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        data_a = v.a;
        data_b = v.b;
        sgn    = v.s;
        start  = 1'b1;
        step();
        start  = 1'b0;
        data_a = WIDTH'($urandom);
        data_b = WIDTH'($urandom);
        sgn    = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("res_cleared_on_start", int'({gt, eq, lt}), 0);
        wait_done(lat, got);
        chk("done_seen", int'(got), 1);
        chk("latency", lat, v.cyc);
        chk("result", int'({gt, eq, lt}), int'(v.res));
        chk("cycles_out", int'(cycles), v.cyc);
        chk("busy_at_done", int'(busy), 0);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("result_held", int'({gt, eq, lt}), int'(v.res));
        chk("cycles_held", int'(cycles), v.cyc);
    endtask

    // Random-phase model state
    logic        m_busy;
    int          m_left;
    logic [2:0]  m_res, m_pend_res;
    int          m_cyc, m_pend_cyc;
    logic        m_done;

    initial begin
        int lat;
        bit got;
        bit seen;
        int ops;

        rst_n  = 1'b0;
        enable = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        sgn    = 1'b0;

        // Reset state
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_res", int'({gt, eq, lt}), 0);
        chk("reset_cycles", int'(cycles), 0);
        #9;
        rst_n  = 1'b1;
        enable = 1'b1;
        step();

        // Directed table
        tbl.push_back('{16'h9234, 16'h1234, 1'b0, 3'b100, 1});
        tbl.push_back('{16'h1234, 16'h1235, 1'b0, 3'b001, 4});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 3'b010, 4});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 3'b010, 4});
        tbl.push_back('{16'h1000, 16'h0FFF, 1'b0, 3'b100, 1});
        tbl.push_back('{16'h1200, 16'h1300, 1'b0, 3'b001, 2});
        tbl.push_back('{16'h1234, 16'h1244, 1'b0, 3'b001, 3});
        tbl.push_back('{16'h8000, 16'h0001, 1'b0, 3'b100, 1});
`ifdef COMPARATOR_SIGNED_EN
        tbl.push_back('{16'h8000, 16'h0001, 1'b1, 3'b001, 1});
        tbl.push_back('{16'hFFFF, 16'h0000, 1'b1, 3'b001, 1});
        tbl.push_back('{16'h7FFF, 16'hFFFE, 1'b1, 3'b100, 1});
`endif
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Abort while idle clears held results
        enable = 1'b0;
        step();
        chk("abort_idle_res", int'({gt, eq, lt}), 0);
        chk("abort_idle_cycles", int'(cycles), 0);
        enable = 1'b1;

        // Start while busy is ignored
        data_a = 16'h1230; data_b = 16'h1231; start = 1'b1;
        step();                                   // T
        start = 1'b0;
        step();                                   // T+1
        chk("ign_no_early_done", int'(done), 0);
        data_a = 16'h9000; data_b = 16'h0000; start = 1'b1;
        step();                                   // T+2
        start = 1'b0;
        chk("ign_still_busy", int'(busy), 1);
        wait_done(lat, got);
        chk("ign_done_seen", int'(got), 1);
        chk("ign_latency", lat, 2);
        chk("ign_result", int'({gt, eq, lt}), 3'b001);
        chk("ign_cycles", int'(cycles), 4);
        step();
        chk("ign_no_second_op", int'(busy || done), 0);

        // Back-to-back: start in the Done cycle is accepted
        data_a = 16'h9234; data_b = 16'h1234; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("b2b_first_done", int'(done), 1);
        data_a = 16'h0000; data_b = 16'h0001; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_accepted", int'(busy), 1);
        chk("b2b_cleared", int'({gt, eq, lt, done}), 0);
        wait_done(lat, got);
        chk("b2b_latency", got ? lat : -1, 4);
        chk("b2b_result", int'({gt, eq, lt}), 3'b001);

        // Enable dropped at T+2 of an all-equal compare
        data_a = 16'h5555; data_b = 16'h5555; start = 1'b1;
        step();                                   // T
        start = 1'b0;
        step();                                   // T+1
        enable = 1'b0;
        step();                                   // T+2
        chk("abort_busy", int'(busy), 0);
        chk("abort_outputs", int'({done, gt, eq, lt}), 0);
        chk("abort_cycles", int'(cycles), 0);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < ND + 2; k++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", int'(seen), 0);

        // Reset pulse mid-operation
        data_a = 16'h5555; data_b = 16'h5555; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_outputs", int'({done, gt, eq, lt, cycles}), 0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < ND + 2; k++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("rst_no_done", int'(seen), 0);

        // Random phase: transaction-level model
        enable = 1'b0;
        step();
        m_busy = 1'b0; m_left = 0; m_res = '0; m_cyc = 0;
        m_pend_res = '0; m_pend_cyc = 0;
        ops = 0;
        for (int c = 0; c < 20000 && ops < 200; c++) begin
            enable = ($urandom_range(0, 24) != 0);
            start  = $urandom_range(0, 1);
            data_a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       data_b = data_a;
                1:       data_b = data_a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                2:       data_b = data_a ^ WIDTH'($urandom_range(0, 255));
                default: data_b = WIDTH'($urandom);
            endcase
`ifdef COMPARATOR_SIGNED_EN
            sgn = $urandom_range(0, 1);
`else
            sgn = 1'b0;
`endif
            m_done = 1'b0;
            if (!enable) begin
                m_busy = 1'b0; m_res = '0; m_cyc = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend_res;
                    m_cyc  = m_pend_cyc;
                end
            end else if (start) begin
                ref_cmp(data_a, data_b, sgn, m_pend_res, m_pend_cyc);
                m_busy = 1'b1;
                m_left = m_pend_cyc;
                m_res  = '0;
                m_cyc  = 0;
                ops++;
            end
            step();
            chk("rnd_busy", int'(busy), int'(m_busy));
            chk("rnd_done", int'(done), int'(m_done));
            chk("rnd_result", int'({gt, eq, lt}), int'(m_res));
            chk("rnd_cycles", int'(cycles), m_cyc);
        end
        chk("rnd_ops_completed", (ops >= 200) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
